// File: rtl/load_seq.sv
// Load sequencer: issues a 1/2/4/8-byte little-endian load as single-byte beats
// on an 8-bit memory port, reporting misalignment and per-beat ack timeout.
module load_seq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  beat_q, beat_d;
  logic [7:0]  wait_q, wait_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;

  // Index of the final beat; doubles as the low-address alignment mask.
  function automatic logic [2:0] last_beat(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          size_d = req_size;
          beat_d = 3'd0;
          wait_d = 8'd0;
          data_d = 64'd0;
          if (|(req_addr[2:0] & last_beat(req_size))) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (mem_ack) begin
          data_d[{beat_q, 3'b000} +: 8] = mem_rdata;
          wait_d = 8'd0;
          beat_d = beat_q + 3'd1;
          if (beat_q == last_beat(size_q)) state_d = RESP;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          // Partial data is discarded so an aborted load always reads back as zero.
          data_d  = 64'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= 64'd0;
      size_q  <= 2'd0;
      beat_q  <= 3'd0;
      wait_q  <= 8'd0;
      data_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep all registers sampling the same pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_rd     = (state_q == READ);
  assign mem_addr   = mem_rd ? (addr_q + {61'd0, beat_q}) : 64'd0;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_valid ? data_q : 64'd0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_load_seq.sv
// Self-checking bench for load_seq: directed loads with a transaction-level
// expectation model compared against the DUT every cycle.
module tb_load_seq;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        mem_rd;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  load_seq #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  typedef enum {P_IDLE, P_READ, P_RESP} phase_e;
  typedef struct {
    logic [63:0] data;
    logic        err;
  } resp_t;

  phase_e      exp_ph = P_IDLE;
  logic [63:0] exp_addr = 64'd0;
  resp_t       exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  req_ready,  1);
    check({tag, "_mem_rd"},     mem_rd,     0);
    check({tag, "_mem_addr"},   mem_addr,   0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"},  resp_data,  0);
    check({tag, "_resp_err"},   resp_err,   0);
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",  req_ready,  exp_ph == P_IDLE);
      check("mem_rd",     mem_rd,     exp_ph == P_READ);
      check("resp_valid", resp_valid, exp_ph == P_RESP);
      if (exp_ph == P_READ) check("mem_addr", mem_addr, exp_addr);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL resp_unexpected: got resp_valid=1 with data %h, required no response", resp_data);
        end else begin
          check("resp_data", resp_data, exp_q[0].data);
          check("resp_err",  resp_err,  exp_q[0].err);
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One load from request to handshake. stall_k/stall_n withhold the ack on one
  // beat; rst_k pulses reset during that beat instead of completing the load.
  task automatic do_load(input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] bytes, input int stall_k, input int stall_n,
                         input int hold, input int rst_k,
                         input logic [63:0] lit_data, input logic lit_err);
    int          n;
    bit          timed;
    resp_t       r;
    logic [63:0] mask;
    n     = 1 << size;
    timed = 1'b0;
    mask  = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    r.data = bytes & mask;
    r.err  = 1'b0;

    req_valid = 1'b1; req_addr = addr; req_size = size;
    mem_ack = 1'b0; resp_ready = 1'b0; exp_ph = P_IDLE;
    step();
    req_valid = 1'b0;

    if ((addr % 64'(n)) != 64'd0) begin
      r.data = 64'd0;
      r.err  = 1'b1;
    end else begin
      exp_ph = P_READ;
      for (int k = 0; k < n && !timed; k++) begin
        exp_addr = addr + 64'(k);
        if (k == rst_k) begin
          reset = 1'b0; mem_ack = 1'b1; mem_rdata = bytes[8*k +: 8];
          step();
          reset = 1'b1; mem_ack = 1'b0; exp_ph = P_IDLE;
          check_idle_outputs("midrst");
          return;
        end
        for (int w = 0; k == stall_k && w < stall_n && !timed; w++) begin
          mem_ack = 1'b0; mem_rdata = 8'hEE;
          step();
          if (w + 1 == TO) timed = 1'b1;
        end
        if (timed) begin
          r.data = 64'd0;
          r.err  = 1'b1;
        end else begin
          mem_ack = 1'b1; mem_rdata = bytes[8*k +: 8];
          step();
          mem_ack = 1'b0;
        end
      end
    end

    exp_q.push_back(r);
    exp_ph = P_RESP;
    // Stray request and ack during the response phase must both be ignored.
    req_valid = (hold > 0); req_addr = addr ^ 64'h1000; req_size = 2'd0;
    mem_ack   = (hold > 0);
    for (int h = 0; h < hold; h++) step();
    resp_ready = 1'b1;
    check("lit_data", resp_data, lit_data);
    check("lit_err",  resp_err,  lit_err);
    step();
    resp_ready = 1'b0; req_valid = 1'b0; mem_ack = 1'b0; exp_ph = P_IDLE;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = 64'd0; req_size = 2'd0;
    mem_rdata = 8'd0; mem_ack = 1'b0; resp_ready = 1'b0;
    repeat (3) step();
    check_idle_outputs("por");
    reset  = 1'b1;
    chk_en = 1'b1;

    do_load(64'h100, 2'd3, 64'h8877665544332211, -1, 0, 0, -1, 64'h8877665544332211, 1'b0);
    do_load(64'h7,   2'd0, 64'hFFFFFFFFFFFFFF80, -1, 0, 0, -1, 64'h0000000000000080, 1'b0);
    do_load(64'h2,   2'd1, 64'hAAAAAAAAAAAA7FFF, -1, 0, 0, -1, 64'h0000000000007FFF, 1'b0);
    do_load(64'h6,   2'd2, 64'h00000000DEADBEEF, -1, 0, 0, -1, 64'd0, 1'b1);
    do_load(64'h40,  2'd2, 64'h00000000A1B2C3D4, 1, TO, 0, -1, 64'd0, 1'b1);
    do_load(64'h40,  2'd2, 64'h00000000A1B2C3D4, 1, TO - 1, 0, -1, 64'h00000000A1B2C3D4, 1'b0);
    do_load(64'h10,  2'd1, 64'h00000000000055AA, -1, 0, 5, -1, 64'h00000000000055AA, 1'b0);
    do_load(64'h3F,  2'd0, 64'h0000000000000001, -1, 0, 0, -1, 64'h0000000000000001, 1'b0);
    do_load(64'h200, 2'd3, 64'h0102030405060708, -1, 0, 0, 3, 64'd0, 1'b0);
    do_load(64'h33,  2'd0, 64'h000000000000005A, -1, 0, 0, -1, 64'h000000000000005A, 1'b0);
    do_load(64'h104, 2'd3, 64'h1122334455667788, -1, 0, 0, -1, 64'd0, 1'b1);
    do_load(64'h1,   2'd1, 64'h0000000000001234, -1, 0, 0, -1, 64'd0, 1'b1);
    do_load(64'h8,   2'd3, 64'hFEDCBA9876543210, 7, 3, 2, -1, 64'hFEDCBA9876543210, 1'b0);

    step();
    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
